sram_io_ctrl_burst: RTL and testbench

//  Parametrised serial-to-SRAM bridge; successor to the 512x8 IO controller.

---
 rtl/sram_io_ctrl_burst_pkg.sv | 11 +
 rtl/sram_io_ctrl_burst_shreg.sv | 36 +++
 rtl/sram_io_ctrl_burst.sv | 100 ++++++++++
 tb/tb_sram_io_ctrl_burst.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sram_io_ctrl_burst_pkg.sv
// sram_io_ctrl_burst_pkg: mode codes, FSM states and frame parity width shared by the SRAM IO bridge.
// Frame parity is present only when SRAM_IO_PARITY_EN is defined.
package sram_io_ctrl_burst_pkg;
    typedef enum logic [1:0] {C_LOAD = 2'b00, C_READ = 2'b01, C_SHIFT = 2'b10, C_WRITE = 2'b11} ctrl_e;
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MEM_REQ, S_MEM_CAP, S_DONE} state_e;
`ifdef SRAM_IO_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
endpackage

// File: rtl/sram_io_ctrl_burst_shreg.sv
// sram_io_ctrl_burst_shreg: {parity,addr,data} frame register with full/data-only shift, data load and addr increment.
// With SRAM_IO_PARITY_EN the MSB even-parity bit is regenerated on data load or addr increment.
module sram_io_ctrl_burst_shreg
    import sram_io_ctrl_burst_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 9,
    parameter int RW = AW + DW + PAR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift_all,
    input  logic          shift_data,
    input  logic          load_data,
    input  logic          inc,
    input  logic          si,
    input  logic [DW-1:0] pi,
    output logic [RW-1:0] q
);
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    assign addr_n = q[AW+DW-1:DW] + AW'(inc);
    assign data_n = load_data ? pi : shift_data ? {si, q[DW-1:1]} : q[DW-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (shift_all)
            q <= {si, q[RW-1:1]};
        else if (shift_data || load_data || inc)
`ifdef SRAM_IO_PARITY_EN
            q <= {(load_data || inc) ? ^{addr_n, data_n} : q[RW-1], addr_n, data_n};
`else
            q <= {addr_n, data_n};
`endif
    end
endmodule

// File: rtl/sram_io_ctrl_burst.sv
// sram_io_ctrl_burst: serial-to-SRAM bridge with frame load, data shift, SRAM read/write and addr auto-increment.
// Optional frame parity check enabled by defining SRAM_IO_PARITY_EN.
module sram_io_ctrl_burst
    import sram_io_ctrl_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bgn,
    input  logic                  load_n,
    input  logic [1:0]            ctrl,
    input  logic                  ainc,
    input  logic                  si,
    input  logic [DATA_WIDTH-1:0] pi,
    output logic                  rdy,
    output logic                  cen,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] po,
    output logic                  so,
    output logic                  perr
);
    localparam int REG_W = ADDR_WIDTH + DATA_WIDTH + PAR_W;
    localparam int CW = $clog2(REG_W + 1);
    state_e state, state_n;
    ctrl_e op;
    logic inc_en, start, last, sh_all, sh_data, ld, inc;
    logic [CW-1:0] cnt;
    logic [REG_W-1:0] q;
    assign start = state == S_IDLE && bgn && !load_n;
    assign last = cnt == CW'(op == C_LOAD ? REG_W - 1 : DATA_WIDTH - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= C_LOAD;
            inc_en <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            op <= ctrl_e'(ctrl);
            inc_en <= ainc;
            cnt <= '0;
        end else if (state == S_SHIFT) begin
            cnt <= cnt + CW'(1);
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    state_n = start ? (ctrl[0] ? S_MEM_REQ : S_SHIFT) : S_IDLE;
            S_SHIFT:   state_n = !bgn ? S_IDLE : last ? S_DONE : S_SHIFT;
            S_MEM_REQ: state_n = !bgn ? S_IDLE : op == C_WRITE ? S_DONE : S_MEM_CAP;
            S_MEM_CAP: state_n = !bgn ? S_IDLE : S_DONE;
            S_DONE:    state_n = bgn ? S_DONE : S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end
    // SRAM strobes are gated by bgn so an abort during MEM_REQ never reaches the macro
    always_comb begin
        rdy = state == S_DONE;
        cen = !(state == S_MEM_REQ && bgn && !(op == C_WRITE && perr));
        wen = !(state == S_MEM_REQ && bgn && op == C_WRITE && !perr);
        sh_all = state == S_SHIFT && bgn && op == C_LOAD;
        sh_data = state == S_SHIFT && bgn && op == C_SHIFT;
        ld = state == S_MEM_CAP && bgn;
        inc = inc_en && bgn && ((state == S_MEM_REQ && op == C_WRITE) || state == S_MEM_CAP);
    end
`ifdef SRAM_IO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perr <= 1'b0;
        else if (start && ctrl == C_LOAD)
            perr <= 1'b0;
        else if (sh_all && last)
            perr <= ^{si, q[REG_W-1:1]};
    end
`else
    assign perr = 1'b0;
`endif
    sram_io_ctrl_burst_shreg #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .RW(REG_W)) u_shreg (
        .clk(clk),
        .rst_n(rst_n),
        .shift_all(sh_all),
        .shift_data(sh_data),
        .load_data(ld),
        .inc(inc),
        .si(si),
        .pi(pi),
        .q(q)
    );
    assign a = q[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign po = q[DATA_WIDTH-1:0];
    assign so = q[0];
endmodule

// File: tb/tb_sram_io_ctrl_burst.sv
// tb_sram_io_ctrl_burst: directed bench with a frame/SRAM model checked every cycle and pinned literal checks.
// Default build (SRAM_IO_PARITY_EN undefined); a one-cycle-latency SRAM model drives PI.
module tb_sram_io_ctrl_burst;
    localparam int DW = 8;
    localparam int AW = 9;
    localparam int RW = AW + DW;
    logic clk = 1'b0;
    logic rst_n, bgn, load_n, ainc, si, rdy, cen, wen, so, perr;
    logic [1:0] ctrl;
    logic [DW-1:0] pi, po, sram_q;
    logic [AW-1:0] a;
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] ex_mem [1<<AW];
    logic [AW-1:0] ex_a;
    logic [DW-1:0] ex_d, so_bits;
    logic ex_rdy, ex_cen, ex_wen, rdy_q = 1'b0;
    int n_chk = 0, n_fail = 0, cyc = 0, t_start = 0, t_rdy = 0, n_cen = 0;

    sram_io_ctrl_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bgn(bgn), .load_n(load_n), .ctrl(ctrl), .ainc(ainc),
        .si(si), .pi(pi), .rdy(rdy), .cen(cen), .wen(wen), .a(a), .po(po), .so(so), .perr(perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!cen) begin
        if (!wen) mem[a] <= po;
        else sram_q <= mem[a];
    end
    assign pi = sram_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rdy", 32'(rdy), 32'(ex_rdy));
        chk("cen", 32'(cen), 32'(ex_cen));
        chk("wen", 32'(wen), 32'(ex_wen));
        chk("a", 32'(a), 32'(ex_a));
        chk("po", 32'(po), 32'(ex_d));
        chk("so", 32'(so), 32'(ex_d[0]));
        chk("perr", 32'(perr), 32'(0));
        if (!cen) n_cen++;
        if (rdy && !rdy_q) t_rdy = cyc;
        rdy_q = rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] c, input logic ai);
        bgn = 1'b1; load_n = 1'b0; ctrl = c; ainc = ai; t_start = cyc;
        tick();
        load_n = 1'b1; ctrl = ~c; ainc = ~ai;
    endtask

    task automatic finish_op();
        bgn = 1'b0;
        tick();
        ex_rdy = 1'b0;
    endtask

    task automatic do_load(input logic [RW-1:0] f, input int nb);
        logic [RW-1:0] m;
        start(2'b00, 1'b0);
        for (int i = 0; i < nb; i++) begin
            si = f[i];
            tick();
            m = {ex_a, ex_d};
            m = {f[i], m[RW-1:1]};
            {ex_a, ex_d} = m;
            ex_rdy = (i == RW - 1);
        end
    endtask

    task automatic do_shift(input logic [DW-1:0] d, input int nb);
        start(2'b10, 1'b0);
        for (int i = 0; i < nb; i++) begin
            si = d[i];
            so_bits[i] = so;
            tick();
            ex_d = {d[i], ex_d[DW-1:1]};
            ex_rdy = (i == DW - 1);
        end
    endtask

    task automatic do_mem(input logic wr, input logic ai);
        start(wr ? 2'b11 : 2'b01, ai);
        ex_cen = 1'b0; ex_wen = !wr;
        if (wr) ex_mem[ex_a] = ex_d;
        tick();
        ex_cen = 1'b1; ex_wen = 1'b1;
        if (!wr) begin
            tick();
            ex_d = ex_mem[ex_a];
        end
        ex_a = ex_a + AW'(ai);
        ex_rdy = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; bgn = 1'b0; load_n = 1'b1; ctrl = 2'b00; ainc = 1'b0; si = 1'b0;
        ex_a = '0; ex_d = '0; ex_rdy = 1'b0; ex_cen = 1'b1; ex_wen = 1'b1; so_bits = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // load then plain write
        do_load({9'h020, 8'h3C}, RW);
        chk("load_a", 32'(a), 32'h020);
        chk("load_po", 32'(po), 32'h3C);
        finish_op();
        chk("load_latency", 32'(t_rdy - t_start), 32'd18);
        do_mem(1'b1, 1'b0);
        finish_op();
        chk("write_latency", 32'(t_rdy - t_start), 32'd2);
        chk("sram_020", 32'(mem[9'h020]), 32'h3C);
        chk("write_a_kept", 32'(a), 32'h020);
        // burst writes with wrap
        do_load({9'h1FE, 8'h00}, RW);
        finish_op();
        do_shift(8'hAB, DW);
        finish_op();
        chk("shift_latency", 32'(t_rdy - t_start), 32'd9);
        do_mem(1'b1, 1'b1);
        finish_op();
        chk("ainc_a", 32'(a), 32'h1FF);
        do_shift(8'hCD, DW);
        finish_op();
        do_mem(1'b1, 1'b1);
        finish_op();
        chk("sram_1fe", 32'(mem[9'h1FE]), 32'hAB);
        chk("sram_1ff", 32'(mem[9'h1FF]), 32'hCD);
        chk("wrap_a", 32'(a), 32'h000);
        // read back then shift out
        do_load({9'h020, 8'h00}, RW);
        finish_op();
        do_mem(1'b0, 1'b0);
        chk("read_po", 32'(po), 32'h3C);
        finish_op();
        chk("read_latency", 32'(t_rdy - t_start), 32'd3);
        do_shift(8'h00, DW);
        finish_op();
        chk("so_seq", 32'(so_bits), 32'b0011_1100);
        chk("cen_pulses", 32'(n_cen), 32'd4);
        // aborts
        do_load({9'h155, 8'h5A}, 5);
        finish_op();
        load_n = 1'b0;
        tick(); tick(); tick();
        start(2'b11, 1'b0);
        bgn = 1'b0;
        tick(); tick();
        chk("abort_cen_pulses", 32'(n_cen), 32'd4);
        chk("abort_sram_020", 32'(mem[9'h020]), 32'h3C);
        // async reset mid-shift
        do_shift(8'h77, 3);
        rst_n = 1'b0; bgn = 1'b0;
        ex_a = '0; ex_d = '0; ex_rdy = 1'b0;
        #1;
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_po", 32'(po), 32'h0);
        chk("rst_cen", 32'(cen), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        do_load({9'h0AA, 8'h55}, RW);
        chk("post_rst_a", 32'(a), 32'h0AA);
        chk("post_rst_po", 32'(po), 32'h55);
        finish_op();
        chk("post_rst_latency", 32'(t_rdy - t_start), 32'd18);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
